vpe_dequant_sched: RTL

Sequencer in front of the VPU dequantizer lane. It holds a per-output-channel FP32 scale table and accepts a channel-major stream of INT32 partial sums for one tile (rows × channels). It presents each psum to the dequantizer together with the scale for its channel and the dequant enable, through one registered valid/ready stage, and signals tile completion.

---
 rtl/vpe_dequant_sched_if.sv | 25 ++
 rtl/vpe_dequant_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vpe_dequant_sched_if.sv
// Psum-in / dequant-out handshake bundle between the tile sequencer and its neighbours.
// master = the side that supplies psums and consumes dequant requests.
interface vpe_dequant_sched_if #(
    parameter int PSUM_WIDTH = 32
);
    logic                  psum_in_valid;
    logic                  psum_in_ready;
    logic [PSUM_WIDTH-1:0] psum_in;
    logic                  deq_valid;
    logic                  deq_ready;
    logic [PSUM_WIDTH-1:0] deq_psum;
    logic [31:0]           deq_scale;
    logic                  deq_enable;
    logic                  deq_last;

    modport master (
        output psum_in_valid, psum_in, deq_ready,
        input  psum_in_ready, deq_valid, deq_psum, deq_scale, deq_enable, deq_last
    );

    modport slave (
        input  psum_in_valid, psum_in, deq_ready,
        output psum_in_ready, deq_valid, deq_psum, deq_scale, deq_enable, deq_last
    );
endinterface

// File: rtl/vpe_dequant_sched.sv
// Tile sequencer for the VPU dequantizer lane: pairs each channel-major psum with its
// channel's FP32 scale through one registered valid/ready stage and flags tile end.
module vpe_dequant_sched #(
    parameter int NUM_CH     = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int AW         = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_scale_we,
    input  logic [AW-1:0]        cfg_scale_addr,
    input  logic [31:0]          cfg_scale_data,
    input  logic                 start,
    input  logic [AW:0]          cfg_num_ch,
    input  logic [CNT_WIDTH-1:0] cfg_num_rows,
    input  logic                 cfg_dequant_en,
    output logic                 busy,
    output logic                 done,
    vpe_dequant_sched_if.slave   io
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                state_q;
    logic [AW:0]           num_ch_q;
    logic [CNT_WIDTH-1:0]  num_rows_q;
    logic                  en_q;
    logic [AW-1:0]         ch_idx_q;
    logic [CNT_WIDTH-1:0]  row_idx_q;

    logic                  deq_valid_q;
    logic                  deq_last_q;
    logic                  deq_enable_q;
    logic [PSUM_WIDTH-1:0] deq_psum_q;
    logic [31:0]           deq_scale_q;

    logic [31:0]           scale_q [NUM_CH];
    logic [NUM_CH-1:0]     scale_we;

    logic                  ch_last;
    logic                  row_last;
    logic                  in_ready;
    logic                  accept;
    logic                  out_fire;
    logic                  cfg_empty;
    logic [AW-1:0]         ch_idx_d;
    logic [CNT_WIDTH-1:0]  row_idx_d;

    // Per-entry decode; addresses past the table never match, so they are dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_we
        assign scale_we[gi] = (state_q == S_IDLE) && cfg_scale_we
                              && ({1'b0, cfg_scale_addr} == (AW+1)'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) scale_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (scale_we[i]) scale_q[i] <= cfg_scale_data;
            end
        end
    end

    assign ch_last   = ({1'b0, ch_idx_q} == (num_ch_q - 1'b1));
    assign row_last  = (row_idx_q == (num_rows_q - 1'b1));
    assign out_fire  = deq_valid_q && io.deq_ready;
    assign in_ready  = (state_q == S_RUN) && (!deq_valid_q || io.deq_ready);
    assign accept    = io.psum_in_valid && in_ready;
    assign ch_idx_d  = ch_last ? '0 : ch_idx_q + 1'b1;
    assign row_idx_d = ch_last ? row_idx_q + 1'b1 : row_idx_q;
    assign cfg_empty = (cfg_num_ch == '0) || (cfg_num_ch > (AW+1)'(NUM_CH))
                       || (cfg_num_rows == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_ch_q     <= '0;
            num_rows_q   <= '0;
            en_q         <= 1'b0;
            ch_idx_q     <= '0;
            row_idx_q    <= '0;
            deq_valid_q  <= 1'b0;
            deq_last_q   <= 1'b0;
            deq_enable_q <= 1'b0;
            deq_psum_q   <= '0;
            deq_scale_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_ch_q   <= cfg_num_ch;
                        num_rows_q <= cfg_num_rows;
                        en_q       <= cfg_dequant_en;
                        ch_idx_q   <= '0;
                        row_idx_q  <= '0;
                        state_q    <= cfg_empty ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        ch_idx_q  <= ch_idx_d;
                        row_idx_q <= row_idx_d;
                        if (ch_last && row_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!deq_valid_q || io.deq_ready) state_q <= S_DONE;
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // A same-cycle accept overwrites the stage, so back-to-back data has no bubble.
            if (accept) begin
                deq_valid_q  <= 1'b1;
                deq_psum_q   <= io.psum_in;
                deq_scale_q  <= scale_q[ch_idx_q];
                deq_enable_q <= en_q;
                deq_last_q   <= ch_last && row_last;
            end else if (out_fire) begin
                deq_valid_q  <= 1'b0;
            end
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign io.psum_in_ready = in_ready;
    assign io.deq_valid     = deq_valid_q;
    assign io.deq_psum      = deq_psum_q;
    assign io.deq_scale     = deq_scale_q;
    assign io.deq_enable    = deq_enable_q;
    assign io.deq_last      = deq_last_q;

endmodule
